// File: rtl/aes_hdr_pkg.sv
// Shared types and constants for the MM2S key-header stripper.
package aes_hdr_pkg;
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DRAIN,
        S_PAYLOAD,
        S_DISCARD
    } hdr_state_t;

    localparam int          C_HDR_BEATS = 2;
    localparam int          C_KEY_WIDTH = 256;
    localparam logic [15:0] C_FULL_KEEP = 16'hffff;
endpackage

// File: rtl/axis_reg_slice.sv
// One-deep registered AXI-Stream stage carrying data and last.
module axis_reg_slice #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_data,
    input  logic         s_last,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         m_valid,
    input  logic         m_ready
);
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;
    logic         valid_q, valid_d;

    // Accepting while the held beat leaves gives full throughput with no bubble.
    assign s_ready = ~valid_q | m_ready;

    always_comb begin
        data_d  = data_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (s_valid && s_ready) begin
            data_d  = s_data;
            last_d  = s_last;
            valid_d = 1'b1;
        end else if (m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_last  = last_q;
    assign m_valid = valid_q;
endmodule

// File: rtl/aes_key_hdr_strip.sv
// Strips the two-beat key header from each MM2S packet, commits the key once
// the AES pipeline is empty and forwards payload beats to the core.
module aes_key_hdr_strip #(
    parameter int C_M_AXIS_MM2S_TDATA_WIDTH = 128,
    parameter int C_KEY_WIDTH               = 256,
    parameter int C_CNT_WIDTH               = 9
) (
    input  logic                                     m_axi_mm2s_aclk,
    input  logic                                     mm2s_prmry_reset_out_n,
    input  logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]     m_axis_mm2s_tdata,
    input  logic [C_M_AXIS_MM2S_TDATA_WIDTH/8-1:0]   m_axis_mm2s_tkeep,
    input  logic                                     m_axis_mm2s_tvalid,
    input  logic                                     m_axis_mm2s_tlast,
    output logic                                     m_axis_mm2s_tready,
    output logic [C_M_AXIS_MM2S_TDATA_WIDTH-1:0]     aes_din_tdata,
    output logic                                     aes_din_tvalid,
    output logic                                     aes_din_tlast,
    input  logic                                     aes_din_tready,
    input  logic                                     aes_retire,
    output logic [C_KEY_WIDTH-1:0]                   aes_key,
    output logic [C_CNT_WIDTH-1:0]                   aes_inflight,
    output logic                                     hdr_err
);
    import aes_hdr_pkg::*;

    localparam int                     DW      = C_M_AXIS_MM2S_TDATA_WIDTH;
    localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};

    hdr_state_t             state_q, state_d;
    logic [C_KEY_WIDTH-1:0] key_pend_q, key_pend_d;
    logic [C_KEY_WIDTH-1:0] aes_key_q, aes_key_d;
    logic [C_CNT_WIDTH-1:0] inflight_q, inflight_d;
    logic                   hdr_err_q, hdr_err_d;
    logic                   rdy_en_q;
    logic                   stream_ready, hs, hdr_bad, room;
    logic                   slice_in_valid, slice_in_ready;
    logic                   issue, retire_ok;
    logic [C_CNT_WIDTH:0]   occupancy;

    // A beat parked in the output register is already committed to issue, so it
    // reserves a counter slot; this keeps the counter from ever passing all-ones.
    assign occupancy = {1'b0, inflight_q} + {{C_CNT_WIDTH{1'b0}}, aes_din_tvalid};
    assign room      = occupancy < {1'b0, CNT_MAX};

    always_comb begin
        stream_ready = 1'b0;
        if (rdy_en_q) begin
            case (state_q)
                S_HDR0, S_HDR1, S_DISCARD: stream_ready = 1'b1;
                S_PAYLOAD:                 stream_ready = slice_in_ready & room;
                default:                   stream_ready = 1'b0;
            endcase
        end
    end

    assign hs             = m_axis_mm2s_tvalid & stream_ready;
    assign hdr_bad        = m_axis_mm2s_tlast | (m_axis_mm2s_tkeep != C_FULL_KEEP);
    assign slice_in_valid = hs & (state_q == S_PAYLOAD);

    always_comb begin
        state_d    = state_q;
        key_pend_d = key_pend_q;
        aes_key_d  = aes_key_q;
        hdr_err_d  = 1'b0;
        case (state_q)
            S_HDR0, S_HDR1: begin
                if (hs) begin
                    if (hdr_bad) begin
                        hdr_err_d = 1'b1;
                        state_d   = m_axis_mm2s_tlast ? S_HDR0 : S_DISCARD;
                    end else if (state_q == S_HDR0) begin
                        key_pend_d[C_KEY_WIDTH-1 -: DW] = m_axis_mm2s_tdata;
                        state_d                         = S_HDR1;
                    end else begin
                        key_pend_d[DW-1:0] = m_axis_mm2s_tdata;
                        state_d            = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!aes_din_tvalid && inflight_q == '0) begin
                    aes_key_d = key_pend_q;
                    state_d   = S_PAYLOAD;
                end
            end
            S_PAYLOAD, S_DISCARD: begin
                if (hs && m_axis_mm2s_tlast) state_d = S_HDR0;
            end
            default: state_d = S_HDR0;
        endcase
    end

    assign issue     = aes_din_tvalid & aes_din_tready;
    assign retire_ok = aes_retire & (inflight_q != '0);

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !retire_ok)      inflight_d = inflight_q + CNT_ONE;
        else if (!issue && retire_ok) inflight_d = inflight_q - CNT_ONE;
    end

    always_ff @(posedge m_axi_mm2s_aclk or negedge mm2s_prmry_reset_out_n) begin
        if (!mm2s_prmry_reset_out_n) begin
            state_q    <= S_HDR0;
            key_pend_q <= '0;
            aes_key_q  <= '0;
            inflight_q <= '0;
            hdr_err_q  <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_pend_q <= key_pend_d;
            aes_key_q  <= aes_key_d;
            inflight_q <= inflight_d;
            hdr_err_q  <= hdr_err_d;
            rdy_en_q   <= 1'b1;
        end
    end

    axis_reg_slice #(.W(DW)) u_din_slice (
        .clk     (m_axi_mm2s_aclk),
        .rst_n   (mm2s_prmry_reset_out_n),
        .s_data  (m_axis_mm2s_tdata),
        .s_last  (m_axis_mm2s_tlast),
        .s_valid (slice_in_valid),
        .s_ready (slice_in_ready),
        .m_data  (aes_din_tdata),
        .m_last  (aes_din_tlast),
        .m_valid (aes_din_tvalid),
        .m_ready (aes_din_tready)
    );

    assign m_axis_mm2s_tready = stream_ready;
    assign aes_key            = aes_key_q;
    assign aes_inflight       = inflight_q;
    assign hdr_err            = hdr_err_q;
endmodule
